// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Recovers the displayed value of an 8-digit multiplexed 7-segment display
//   by watching its digit-select and segment buses. Each digit is sampled once
//   its select has been stable long enough. Digits are collected into a shadow
//   frame, and the frame is published atomically once all eight digits have
//   been seen.
//
// Optional feature macro: SEG_CAPTURE_DP_EN
//   When defined, the decimal point is captured per digit and driven on dp_out.
//   When undefined, dp_out does not exist and seg[7] is ignored.
//
// Ports
//   CLK_50        in   1   sole clock, rising edge
//   nCR           in   1   asynchronous active-low reset
//   sel           in   8   digit select, bit n selects digit n
//   seg           in   8   segment bus, bit 7 dp, bits 6..0 g..a
//   digit_code    out 32   hex code per digit, digit n at bits 4n+3..4n
//   digit_valid   out  8   digit n decoded to a legal pattern in the last frame
//   frame_done    out  1   one-cycle pulse when a frame is published
//   frame_changed out  1   pulse with frame_done when published content changed
//   scan_lost     out  1   no capture seen for TIMEOUT_CYC cycles
//   dp_out        out  8   decimal point per digit (SEG_CAPTURE_DP_EN only)
//
// FSM states
//   state     | meaning
//   ST_BLANK  | select is all-zero or multi-hot; nothing to sample
//   ST_SETTLE | select is one-hot and is counting stable cycles
//   ST_HELD   | digit captured; waiting for the select to change
module seg_scan_capture #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 500000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        CLK_50,
  input  logic        nCR,
  input  logic [7:0]  sel,
  input  logic [7:0]  seg,
  output logic [31:0] digit_code,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        frame_changed,
  output logic        scan_lost
`ifdef SEG_CAPTURE_DP_EN
  ,
  output logic [7:0]  dp_out
`endif
);

  localparam int            IW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDLE_MAX    = IW'(TIMEOUT_CYC);
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {ST_BLANK, ST_SETTLE, ST_HELD} state_t;

  // Two-stage input synchronisers.
  logic [7:0] sel_s1_q, sel_s2_q;
  logic [7:0] seg_s1_q, seg_s2_q;

  always_ff @(posedge CLK_50 or negedge nCR) begin
    if (!nCR) begin
      sel_s1_q <= '0;
      sel_s2_q <= '0;
      seg_s1_q <= '0;
      seg_s2_q <= '0;
    end else begin
      sel_s1_q <= sel;
      sel_s2_q <= sel_s1_q;
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
    end
  end

  // Everything downstream works on active-high select and segments.
  logic [7:0] sel_n, seg_n;
  assign sel_n = ACTIVE_LOW ? ~sel_s2_q : sel_s2_q;
  assign seg_n = ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;

  state_t        state_q;
  logic [7:0]    sel_prev_q;
  logic [7:0]    cnt_q;
  logic [IW-1:0] idle_q;
  logic [7:0]    mask_q;
  logic [31:0]   shadow_code_q;
  logic [7:0]    shadow_valid_q;
  logic [31:0]   digit_code_q;
  logic [7:0]    digit_valid_q;
  logic          frame_done_q;
  logic          frame_changed_q;
  logic          scan_lost_q;
`ifdef SEG_CAPTURE_DP_EN
  logic [7:0]    shadow_dp_q;
  logic [7:0]    dp_q;
`else
  logic          unused_seg_dp;
  assign unused_seg_dp = seg_n[7];
`endif

  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic       sel_change, sel_onehot, capture, mask_full, pub_diff;
  logic [2:0] sel_idx;
  logic [4:0] cap_dec;

  assign sel_change = (sel_n != sel_prev_q);
  assign sel_onehot = (sel_n != 8'h00) && ((sel_n & (sel_n - 8'd1)) == 8'h00);
  assign capture    = (state_q == ST_SETTLE) && !sel_change && (cnt_q == SETTLE_LAST);
  assign mask_full  = (mask_q == 8'hFF);
  assign cap_dec    = seg_decode(seg_n[6:0]);

`ifdef SEG_CAPTURE_DP_EN
  assign pub_diff = {shadow_code_q, shadow_valid_q, shadow_dp_q} !=
                    {digit_code_q, digit_valid_q, dp_q};
`else
  assign pub_diff = {shadow_code_q, shadow_valid_q} != {digit_code_q, digit_valid_q};
`endif

  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel_n[i]) sel_idx = 3'(i);
    end
  end

  always_ff @(posedge CLK_50 or negedge nCR) begin
    if (!nCR) begin
      state_q         <= ST_BLANK;
      sel_prev_q      <= '0;
      cnt_q           <= '0;
      idle_q          <= '0;
      mask_q          <= '0;
      shadow_code_q   <= '0;
      shadow_valid_q  <= '0;
      digit_code_q    <= '0;
      digit_valid_q   <= '0;
      frame_done_q    <= 1'b0;
      frame_changed_q <= 1'b0;
      scan_lost_q     <= 1'b0;
`ifdef SEG_CAPTURE_DP_EN
      shadow_dp_q     <= '0;
      dp_q            <= '0;
`endif
    end else begin
      frame_done_q    <= 1'b0;
      frame_changed_q <= 1'b0;

      if (sel_change) begin
        sel_prev_q <= sel_n;
        cnt_q      <= '0;
        state_q    <= sel_onehot ? ST_SETTLE : ST_BLANK;
      end else if (state_q == ST_SETTLE) begin
        if (cnt_q == SETTLE_LAST) state_q <= ST_HELD;
        else                      cnt_q   <= cnt_q + 8'd1;
      end

      if (capture) begin
        shadow_code_q[{sel_idx, 2'b00} +: 4] <= cap_dec[3:0];
        shadow_valid_q[sel_idx]              <= cap_dec[4];
`ifdef SEG_CAPTURE_DP_EN
        shadow_dp_q[sel_idx]                 <= seg_n[7];
`endif
        // A capture landing on the publish cycle starts the next frame.
        mask_q      <= (mask_full ? 8'h00 : mask_q) | sel_n;
        idle_q      <= '0;
        scan_lost_q <= 1'b0;
      end else if (idle_q == IDLE_MAX) begin
        // Stalled scan: drop the partial frame so a full one is needed again.
        scan_lost_q <= 1'b1;
        mask_q      <= '0;
      end else begin
        idle_q <= idle_q + IW'(1);
        if (mask_full) mask_q <= '0;
      end

      // The completing capture is already in the shadow when the mask reads full.
      if (mask_full) begin
        digit_code_q    <= shadow_code_q;
        digit_valid_q   <= shadow_valid_q;
`ifdef SEG_CAPTURE_DP_EN
        dp_q            <= shadow_dp_q;
`endif
        frame_done_q    <= 1'b1;
        frame_changed_q <= pub_diff;
      end
    end
  end

  assign digit_code    = digit_code_q;
  assign digit_valid   = digit_valid_q;
  assign frame_done    = frame_done_q;
  assign frame_changed = frame_changed_q;
  assign scan_lost     = scan_lost_q;
`ifdef SEG_CAPTURE_DP_EN
  assign dp_out        = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

  localparam int SETTLE = 16;
  localparam int TMO    = 3000;

  logic        CLK_50 = 1'b0;
  logic        nCR    = 1'b0;
  logic [7:0]  sel    = 8'hFF;
  logic [7:0]  seg    = 8'hFF;
  logic [31:0] digit_code;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        frame_changed;
  logic        scan_lost;
`ifdef SEG_CAPTURE_DP_EN
  logic [7:0]  dp_out;
`endif

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  int fc_cnt = 0;

  // Digit d shows the numeral d+1.
  logic [7:0] pat [0:7] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};

  seg_scan_capture #(
    .SETTLE_CYC (SETTLE),
    .TIMEOUT_CYC(TMO),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .CLK_50       (CLK_50),
    .nCR          (nCR),
    .sel          (sel),
    .seg          (seg),
    .digit_code   (digit_code),
    .digit_valid  (digit_valid),
    .frame_done   (frame_done),
    .frame_changed(frame_changed),
    .scan_lost    (scan_lost)
`ifdef SEG_CAPTURE_DP_EN
    ,
    .dp_out       (dp_out)
`endif
  );

  always #10 CLK_50 = ~CLK_50;

  always @(posedge CLK_50) begin
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      if (frame_changed) fc_cnt <= fc_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one digit (active-low buses) for hold cycles; p is active-high incl. dp.
  task automatic show(input int d, input logic [7:0] p, input int hold);
    sel = ~(8'h01 << d);
    seg = ~p;
    repeat (hold) @(negedge CLK_50);
  endtask

  task automatic blank(input int n);
    sel = 8'hFF;
    seg = 8'hFF;
    repeat (n) @(negedge CLK_50);
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge CLK_50);
    check("rst_code", digit_code, 32'h0);
    check("rst_valid", {24'h0, digit_valid}, 32'h0);
    check("rst_fd", {31'h0, frame_done}, 32'h0);
    check("rst_fc", {31'h0, frame_changed}, 32'h0);
    check("rst_lost", {31'h0, scan_lost}, 32'h0);
    nCR = 1'b1;
    @(negedge CLK_50);

    // First frame "12345678", 1000 cycles per digit
    for (int d = 0; d < 7; d++) show(d, pat[d], 1000);
    check("f1_no_early_done", fd_cnt, 0);
    show(7, pat[7], 1000);
    check("f1_done", fd_cnt, 1);
    check("f1_changed", fc_cnt, 1);
    check("f1_code", digit_code, 32'h87654321);
    check("f1_valid", {24'h0, digit_valid}, 32'hFF);
    check("f1_lost", {31'h0, scan_lost}, 32'h0);

    // Identical frame: done without change
    for (int d = 0; d < 8; d++) show(d, pat[d], 40);
    check("f2_done", fd_cnt, 2);
    check("f2_unchanged", fc_cnt, 1);
    check("f2_code", digit_code, 32'h87654321);

    // Digit 3 too short to settle; frame completes only once it is rescanned
    for (int d = 0; d < 3; d++) show(d, pat[d], 40);
    show(3, pat[3], SETTLE - 2);
    for (int d = 4; d < 8; d++) show(d, pat[d], 40);
    check("short_no_done", fd_cnt, 2);
    show(3, pat[3], 40);
    check("short_rescan_done", fd_cnt, 3);
    check("short_unchanged", fc_cnt, 1);

    // Illegal pattern on digit 5
    for (int d = 0; d < 8; d++) show(d, (d == 5) ? 8'h49 : pat[d], 40);
    check("bad_done", fd_cnt, 4);
    check("bad_changed", fc_cnt, 2);
    check("bad_code", digit_code, 32'h87054321);
    check("bad_valid", {24'h0, digit_valid}, 32'hDF);

    // Stalled scan after a partial frame
    for (int d = 0; d < 4; d++) show(d, pat[d], 40);
    blank(TMO - 100);
    check("tmo_not_yet", {31'h0, scan_lost}, 32'h0);
    blank(160);
    check("tmo_lost", {31'h0, scan_lost}, 32'h1);
    check("tmo_hold_code", digit_code, 32'h87054321);
    check("tmo_hold_valid", {24'h0, digit_valid}, 32'hDF);
    check("tmo_no_done", fd_cnt, 4);
    show(4, pat[4], 40);
    check("tmo_resume_lost", {31'h0, scan_lost}, 32'h0);
    for (int d = 5; d < 8; d++) show(d, pat[d], 40);
    check("tmo_partial_discarded", fd_cnt, 4);
    for (int d = 0; d < 4; d++) show(d, pat[d], 40);
    check("tmo_full_done", fd_cnt, 5);
    check("tmo_changed", fc_cnt, 3);
    check("tmo_code", digit_code, 32'h87654321);
    check("tmo_valid", {24'h0, digit_valid}, 32'hFF);

    // Reset mid-frame after four digits
    for (int d = 0; d < 4; d++) show(d, pat[d], 40);
    sel = 8'hFF;
    seg = 8'hFF;
    nCR = 1'b0;
    repeat (3) @(negedge CLK_50);
    check("mrst_code", digit_code, 32'h0);
    check("mrst_valid", {24'h0, digit_valid}, 32'h0);
    check("mrst_lost", {31'h0, scan_lost}, 32'h0);
    check("mrst_fd", {31'h0, frame_done}, 32'h0);
    check("mrst_fc", {31'h0, frame_changed}, 32'h0);
`ifdef SEG_CAPTURE_DP_EN
    check("mrst_dp", {24'h0, dp_out}, 32'h0);
`endif
    nCR = 1'b1;
    @(negedge CLK_50);
    for (int d = 4; d < 8; d++) show(d, pat[d], 40);
    check("mrst_partial_no_done", fd_cnt, 5);
    for (int d = 0; d < 4; d++) show(d, (d == 2) ? (pat[d] | 8'h80) : pat[d], 40);
    check("mrst_done", fd_cnt, 6);
    check("mrst_changed", fc_cnt, 4);
    check("mrst_code_after", digit_code, 32'h87654321);
    check("mrst_valid_after", {24'h0, digit_valid}, 32'hFF);
`ifdef SEG_CAPTURE_DP_EN
    check("mrst_dp_after", {24'h0, dp_out}, 32'h04);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
